multicycle_core: RTL and testbench

Parametrised multi-cycle MIPS-subset core that succeeds the single-cycle datapath. Instructions execute as a FETCH/DECODE/EXEC/MEM/WB state sequence that shares one ALU and one external memory port. Memory is reached through a req/ready handshake with arbitrary wait states. Adds a hardwired-zero r0, a synchronous reset, a halt instruction and a retired-instruction counter.

---
 rtl/multicycle_core.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_core: multi-cycle MIPS-subset core, one ALU, one memory port. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_core #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [5:0]       HALT_OP  = 6'h3f,
  parameter int               CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_halt   = 3'd5;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_ori   = 6'h0d;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_target;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_alu_out;
  logic [31:0]       r_mdr;
  logic [31:0]       r_regs [0:31];
  logic [CNT_W-1:0]  r_instret;
  logic              r_hold;

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [5:0]        w_funct;
  logic [31:0]       w_sext;
  logic [31:0]       w_zext;
  logic [31:0]       w_sext_sh;
  logic [31:0]       w_pc32;
  logic [31:0]       w_jt32;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_br_target;
  logic [31:0]       w_alu;
  logic              w_funct_ok;
  logic              w_mem_fire;
  logic [4:0]        w_dest;
  logic [31:0]       w_wb_data;
  logic              w_unused;

  assign w_op        = r_ir[31:26];
  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_funct     = r_ir[5:0];
  assign w_sext      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext      = {16'h0000, r_ir[15:0]};
  assign w_sext_sh   = {w_sext[29:0], 2'b00};
  assign w_pc32      = 32'(r_pc);
  assign w_jt32      = {w_pc32[31:28], r_ir[25:0], 2'b00};
  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  assign w_br_target = r_pc + w_sext_sh[ADDR_W-1:0];
  assign w_mem_fire  = mem_req & mem_ready;
  assign w_dest      = (w_op == c_op_rtype) ? w_rd : w_rt;
  assign w_wb_data   = (w_op == c_op_lw) ? r_mdr : r_alu_out;
  assign w_unused    = ^{r_ir, r_alu_out, w_jt32, w_sext_sh};

  always_comb begin
    w_alu      = 32'h0;
    w_funct_ok = 1'b0;
    case (w_op)
      c_op_rtype: begin
        w_funct_ok = 1'b1;
        case (w_funct)
          6'h20:   w_alu = r_a + r_b;
          6'h22:   w_alu = r_a - r_b;
          6'h24:   w_alu = r_a & r_b;
          6'h25:   w_alu = r_a | r_b;
          6'h2a:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
          default: w_funct_ok = 1'b0;
        endcase
      end
      c_op_ori:                     w_alu = r_a | w_zext;
      c_op_addi, c_op_lw, c_op_sw:  w_alu = r_a + w_sext;
      default:                      w_alu = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_fetch;
      r_pc      <= PC_RESET;
      r_target  <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_instret <= '0;
      r_hold    <= 1'b1;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_hold <= 1'b0;
      case (r_state)
        c_st_fetch: begin
          if (w_mem_fire) begin
            r_ir    <= mem_rdata;
            r_pc    <= w_pc_plus4;
            r_state <= c_st_decode;
          end
        end
        c_st_decode: begin
          r_a      <= r_regs[w_rs];
          r_b      <= r_regs[w_rt];
          r_target <= w_br_target;
          r_state  <= (w_op == HALT_OP) ? c_st_halt : c_st_exec;
        end
        c_st_exec: begin
          r_alu_out <= w_alu;
          case (w_op)
            c_op_rtype: begin
              if (w_funct_ok) begin
                r_state <= c_st_wb;
              end else begin
                r_instret <= r_instret + CNT_W'(1);
                r_state   <= c_st_fetch;
              end
            end
            c_op_addi, c_op_ori: r_state <= c_st_wb;
            c_op_lw, c_op_sw:    r_state <= c_st_mem;
            c_op_beq, c_op_bne: begin
              if ((r_a == r_b) == (w_op == c_op_beq)) r_pc <= r_target;
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= c_st_fetch;
            end
            c_op_j, c_op_jal: begin
              // r_pc already holds the link address (jal's pc+4)
              r_pc <= w_jt32[ADDR_W-1:0];
              if (w_op == c_op_jal) r_regs[31] <= w_pc32;
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= c_st_fetch;
            end
            default: begin
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= c_st_fetch;
            end
          endcase
        end
        c_st_mem: begin
          if (w_mem_fire) begin
            if (w_op == c_op_lw) begin
              r_mdr   <= mem_rdata;
              r_state <= c_st_wb;
            end else begin
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= c_st_fetch;
            end
          end
        end
        c_st_wb: begin
          if (w_dest != 5'd0) r_regs[w_dest] <= w_wb_data;
          r_instret <= r_instret + CNT_W'(1);
          r_state   <= c_st_fetch;
        end
        c_st_halt: r_state <= c_st_halt;
        default:   r_state <= c_st_fetch;
      endcase
    end
  end

  // No request in the cycle following reset, so an abandoned access is never re-issued mid-reset.
  assign mem_req   = ~r_hold & ((r_state == c_st_fetch) | (r_state == c_st_mem));
  assign mem_we    = (r_state == c_st_mem) & (w_op == c_op_sw);
  assign mem_addr  = (r_state == c_st_mem) ? {r_alu_out[ADDR_W-1:2], 2'b00} : r_pc;
  assign mem_wdata = r_b;
  assign halted    = (r_state == c_st_halt);
  assign pc_out    = r_pc;
  assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_core: directed programs against a wait-state memory model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  logic        mem_ready = 1'b0;
  logic        halted;
  logic [15:0] pc_out;
  logic [31:0] instret;

  logic [31:0] mem [0:255];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0;
  logic        pend_we = 1'b0;
  int          wr_count = 0;
  logic [15:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] c_halt = 32'hFC000000;

  multicycle_core #(
    .ADDR_W   (16),
    .PC_RESET (16'h0000),
    .HALT_OP  (6'h3f),
    .CNT_W    (32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc_out    (pc_out),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Memory answers after wait_cfg stalled request cycles; outputs must hold while stalled.
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt      = 0;
      pend      = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'hDEADBEEF;
    end else begin
      if (pend) begin
        check("hold_addr", 32'(mem_addr), 32'(pend_addr));
        check("hold_we", 32'(mem_we), 32'(pend_we));
      end
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        wcnt      = 0;
        pend      = 1'b0;
        check("addr_align", 32'(mem_addr[1:0]), 32'h0);
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          wr_count++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          mem_rdata    = 32'hDEADBEEF;
        end else begin
          mem_rdata = mem[mem_addr[9:2]];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        wcnt++;
        pend      = 1'b1;
        pend_addr = mem_addr;
        pend_we   = mem_we;
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int addr);
    return {op[5:0], addr[27:2]};
  endfunction

  function automatic logic [31:0] rf(input int idx);
    return u_dut.r_regs[idx];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wr_count = 0;
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    mem[addr >> 2] = word;
  endtask

  // Leaves the bench in cycle 1: the first fetch request cycle after reset.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    @(posedge clk);
    #1;
    check("first_fetch_req", 32'(mem_req), 32'h1);
    check("first_fetch_addr", 32'(mem_addr), 32'h0);
  endtask

  task automatic run_to_halt(input int limit, output int cyc);
    cyc = 0;
    while (!halted && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!halted) check("halt_timeout", 32'(halted), 32'h1);
  endtask

  initial begin
    int cyc;
    int nz;

    // Arithmetic program, zero-wait then two wait states per access
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      put(32'h00, enc_i(8, 0, 1, 5));
      put(32'h04, enc_i(8, 0, 2, 7));
      put(32'h08, enc_r(1, 2, 3, 32'h20));
      put(32'h0c, c_halt);
      wait_cfg = (pass == 0) ? 0 : 2;
      do_reset();
      run_to_halt(100, cyc);
      check(pass == 0 ? "t1_cycles" : "t2_cycles", 32'(cyc), pass == 0 ? 32'd14 : 32'd22);
      check("t1_r1", rf(1), 32'd5);
      check("t1_r2", rf(2), 32'd7);
      check("t1_r3", rf(3), 32'd12);
      check("t1_instret", instret, 32'd3);
      check("t1_pc", 32'(pc_out), 32'h10);
      repeat (5) @(posedge clk);
      #1;
      check("t1_halt_hold", 32'(halted), 32'h1);
      check("t1_pc_frozen", 32'(pc_out), 32'h10);
      check("t1_halt_noreq", 32'(mem_req), 32'h0);
    end

    // Store/load round trip, including an unaligned effective address
    clear_mem();
    put(32'h00, enc_j(2, 32'h20));
    put(32'h20, enc_i(32'h23, 0, 3, 32'h80));
    put(32'h24, enc_i(32'h2b, 0, 3, 32'h08));
    put(32'h28, enc_i(32'h23, 0, 4, 32'h08));
    put(32'h2c, enc_i(32'h23, 0, 5, 32'h0b));
    put(32'h30, c_halt);
    put(32'h80, 32'hA1B2C3D4);
    wait_cfg = 1;
    do_reset();
    run_to_halt(200, cyc);
    check("t3_cycles", 32'(cyc), 32'd34);
    check("t3_r3", rf(3), 32'hA1B2C3D4);
    check("t3_wr_count", 32'(wr_count), 32'd1);
    check("t3_wr_addr", 32'(last_wr_addr), 32'h08);
    check("t3_wr_data", last_wr_data, 32'hA1B2C3D4);
    check("t3_r4", rf(4), 32'hA1B2C3D4);
    check("t3_r5_unaligned", rf(5), 32'hA1B2C3D4);
    check("t3_instret", instret, 32'd5);
    check("t3_pc", 32'(pc_out), 32'h34);

    // Branches, r0 write suppression and the remaining ALU ops
    clear_mem();
    put(32'h00, enc_i(4, 1, 1, 2));
    put(32'h04, enc_i(8, 0, 6, 1));
    put(32'h08, enc_i(8, 0, 6, 2));
    put(32'h0c, enc_i(5, 1, 1, 2));
    put(32'h10, enc_i(8, 0, 0, 9));
    put(32'h14, enc_i(8, 0, 7, 32'h55));
    put(32'h18, enc_i(32'h0d, 0, 8, 32'h8001));
    put(32'h1c, enc_i(8, 0, 9, 32'hffff));
    put(32'h20, enc_r(9, 8, 10, 32'h2a));
    put(32'h24, enc_r(8, 9, 11, 32'h22));
    put(32'h28, enc_r(11, 8, 12, 32'h24));
    put(32'h2c, enc_r(11, 8, 13, 32'h25));
    put(32'h30, c_halt);
    wait_cfg = 0;
    do_reset();
    run_to_halt(200, cyc);
    check("t4_cycles", 32'(cyc), 32'd40);
    check("t4_beq_skip_r6", rf(6), 32'h0);
    check("t4_bne_fall_r7", rf(7), 32'h55);
    check("t4_r0", rf(0), 32'h0);
    check("t4_ori_zext", rf(8), 32'h00008001);
    check("t4_addi_sext", rf(9), 32'hFFFFFFFF);
    check("t4_slt_signed", rf(10), 32'h1);
    check("t4_sub", rf(11), 32'h00008002);
    check("t4_and", rf(12), 32'h00008000);
    check("t4_or", rf(13), 32'h00008003);
    check("t4_instret", instret, 32'd10);
    check("t4_pc", 32'(pc_out), 32'h34);

    // jal link, unknown opcode and unknown funct as nops
    clear_mem();
    put(32'h00, enc_j(2, 32'h20));
    put(32'h20, enc_j(3, 32'h40));
    put(32'h40, 32'hF8000000);
    put(32'h44, enc_r(1, 1, 14, 32'h3f));
    put(32'h48, c_halt);
    do_reset();
    run_to_halt(100, cyc);
    check("t5_cycles", 32'(cyc), 32'd14);
    check("t5_r31", rf(31), 32'h24);
    check("t5_r14", rf(14), 32'h0);
    check("t5_instret", instret, 32'd4);
    check("t5_pc", 32'(pc_out), 32'h4c);

    // Reset in the middle of a stalled load
    clear_mem();
    put(32'h00, enc_i(8, 0, 1, 5));
    put(32'h04, enc_i(32'h23, 0, 2, 32'h80));
    put(32'h08, c_halt);
    put(32'h80, 32'h12345678);
    wait_cfg = 3;
    do_reset();
    cyc = 0;
    while (!(mem_req && mem_addr == 16'h0080) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t6_reach_lw_mem", 32'(mem_addr), 32'h80);
    @(posedge clk);
    #1;
    check("t6_mid_wait", 32'(mem_req & ~mem_ready), 32'h1);
    check("t6_pre_instret", instret, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_pc", 32'(pc_out), 32'h0);
    check("t6_rst_req", 32'(mem_req), 32'h0);
    check("t6_rst_instret", instret, 32'h0);
    check("t6_rst_halted", 32'(halted), 32'h0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf(i) != 32'h0) nz++;
    check("t6_rst_regs_nonzero", 32'(nz), 32'h0);
    wait_cfg = 0;
    @(posedge clk);
    #1;
    check("t6_refetch_req", 32'(mem_req), 32'h1);
    check("t6_refetch_addr", 32'(mem_addr), 32'h0);
    run_to_halt(100, cyc);
    check("t6_cycles", 32'(cyc), 32'd11);
    check("t6_r1", rf(1), 32'd5);
    check("t6_r2", rf(2), 32'h12345678);
    check("t6_instret", instret, 32'd2);
    check("t6_pc", 32'(pc_out), 32'h0c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
